// File: rtl/fix_pkg.sv
// Shared definitions for the fixed-point MAC back end:
// default widths, FSM state encoding and format conversion helpers.
package fix_pkg;

  localparam int Q_DEF     = 8;
  localparam int N_DEF     = 16;
  localparam int GUARD_DEF = 8;
  localparam int AW_DEF    = N_DEF + GUARD_DEF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic signed [AW_DEF-1:0] sm_to_tc(
    input logic [N_DEF-1:0] sm
  );
    logic signed [AW_DEF-1:0] m;
    m = {{(GUARD_DEF+1){1'b0}}, sm[N_DEF-2:0]};
    return sm[N_DEF-1] ? -m : m;
  endfunction

  // Returns {sat, sign-magnitude word}; zero always comes out positive.
  function automatic logic [N_DEF:0] tc_to_sm_sat(
    input logic signed [AW_DEF-1:0] acc
  );
    logic signed [AW_DEF-1:0] maxm;
    logic signed [AW_DEF-1:0] neg;
    maxm = {{(GUARD_DEF+1){1'b0}}, {(N_DEF-1){1'b1}}};
    neg  = -acc;
    if (acc > maxm)
      return {2'b10, {(N_DEF-1){1'b1}}};
    else if (acc < -maxm)
      return {2'b11, {(N_DEF-1){1'b1}}};
    else if (acc[AW_DEF-1])
      return {2'b01, neg[N_DEF-2:0]};
    else
      return {2'b00, acc[N_DEF-2:0]};
  endfunction

endpackage

// File: rtl/fix_sm2tc.sv
// Sign-magnitude to two's-complement converter, sign-extended
// to the accumulator width; negative zero maps to zero.
module fix_sm2tc #(
  parameter int N  = 16,
  parameter int AW = 24
) (
  input  logic [N-1:0]         i_sm,
  output logic signed [AW-1:0] o_tc
);

  logic signed [AW-1:0] w_mag;

  assign w_mag = {{(AW-N+1){1'b0}}, i_sm[N-2:0]};
  assign o_tc  = i_sm[N-1] ? -w_mag : w_mag;

endmodule

// File: rtl/fix_accum.sv
// Streaming accumulator for sign-magnitude products: sums a
// programmed number of beats and returns a saturated SM result.
module fix_accum
  import fix_pkg::*;
#(
  parameter int Q     = Q_DEF,
  parameter int N     = N_DEF,
  parameter int LEN_W = 8,
  parameter int GUARD = GUARD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_sat,
  output logic             busy
);

  localparam int AW = N + GUARD;

  generate
    if (GUARD < LEN_W) begin : g_guard_chk
      $error("fix_accum: GUARD must be >= LEN_W");
    end
    if (Q >= N) begin : g_q_chk
      $error("fix_accum: Q must be < N");
    end
  endgenerate

  localparam logic signed [AW-1:0] MAXM =
    {{(GUARD+1){1'b0}}, {(N-1){1'b1}}};

  state_t               r_state;
  logic signed [AW-1:0] r_acc;
  logic [LEN_W-1:0]     r_cnt;
  logic [LEN_W-1:0]     r_len;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [N-1:0]         r_out_data;
  logic                 r_out_sat;
  logic                 r_busy;

  logic signed [AW-1:0] w_tc;
  logic signed [AW-1:0] w_acc_nxt;
  logic signed [AW-1:0] w_res;
  logic signed [AW-1:0] w_neg;
  logic [N-1:0]         w_sm;
  logic                 w_sat;
  logic                 w_take;
  logic                 w_last;

  fix_sm2tc #(.N(N), .AW(AW)) u_sm2tc (
    .i_sm (in_data),
    .o_tc (w_tc)
  );

  assign w_take    = r_in_ready & in_valid;
  assign w_last    = (r_cnt == r_len - LEN_W'(1));
  assign w_acc_nxt = r_acc + w_tc;

  // Zero-length jobs resolve straight from IDLE with an empty sum.
  always_comb begin
    w_res = (r_state == S_IDLE) ? '0 : w_acc_nxt;
    w_neg = -w_res;
    w_sat = 1'b0;
    w_sm  = '0;
    if (w_res > MAXM) begin
      w_sat = 1'b1;
      w_sm  = {1'b0, {(N-1){1'b1}}};
    end else if (w_res < -MAXM) begin
      w_sat = 1'b1;
      w_sm  = {1'b1, {(N-1){1'b1}}};
    end else if (w_res[AW-1]) begin
      w_sm  = {1'b1, w_neg[N-2:0]};
    end else begin
      w_sm  = {1'b0, w_res[N-2:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_len  <= len;
            r_busy <= 1'b1;
            if (len != '0) begin
              r_state    <= S_ACCUM;
              r_in_ready <= 1'b1;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_data  <= w_sm;
              r_out_sat   <= w_sat;
            end
          end
        end
        S_ACCUM: begin
          if (w_take) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + LEN_W'(1);
            if (w_last) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_sm;
              r_out_sat   <= w_sat;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fix_accum.sv
// Randomized bench for fix_accum against an arithmetic model
// of the sum-and-saturate behaviour, plus literal anchor cases.
module tb_fix_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] beats [0:255];
  logic [15:0] exp_data;
  logic        exp_sat;
  bit          armed = 1'b0;
  logic [15:0] got_data;
  logic        got_sat;

  fix_accum dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Plain integer sum of the beats, then clip to +/-MAXM.
  function automatic void model(input int n, output logic [15:0] d,
                                output logic s, output longint sum);
    longint a;
    longint m;
    a = 0;
    for (int i = 0; i < n; i++) begin
      m = 0;
      m[14:0] = beats[i][14:0];
      a += beats[i][15] ? -m : m;
    end
    sum = a;
    m = (a < 0) ? -a : a;
    if (a > 32767) begin
      d = 16'h7FFF; s = 1'b1;
    end else if (a < -32767) begin
      d = 16'hFFFF; s = 1'b1;
    end else begin
      s = 1'b0;
      d = {(a < 0), m[14:0]};
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (!armed)
        chk("no out_valid when idle", out_valid, 0);
      else if (out_valid) begin
        chk("out_data", out_data, exp_data);
        chk("out_sat", out_sat, exp_sat);
      end
    end
  end

  task automatic txn(input int n, input int gapmax, input int hold,
                     input bit glitch, input bit acc_chk);
    logic [15:0] d;
    logic        s;
    longint      sum;
    logic [15:0] held;
    int          k;
    int          gap;
    model(n, d, s, sum);
    exp_data = d;
    exp_sat  = s;
    armed    = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    len   = n[7:0];
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy after start", busy, 1);
    for (int i = 0; i < n; i++) begin
      gap = (gapmax == 0) ? 0 : $urandom_range(gapmax, 1);
      repeat (gap) begin
        in_valid = 1'b0;
        start    = glitch;
        @(posedge clk); #1;
        start    = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = beats[i];
      k = 0;
      while (!in_ready && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      if (k >= 50) chk("in_ready timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = $urandom;
    end
    chk("latency out_valid", out_valid, 1);
    chk("in_ready low in done", in_ready, 0);
    if (acc_chk) chk("internal acc", dut.r_acc, 64'd8355585);
    held     = out_data;
    got_data = out_data;
    got_sat  = out_sat;
    repeat (hold) begin
      start = glitch;
      @(posedge clk); #1;
      start = 1'b0;
      chk("held valid", out_valid, 1);
      chk("held data stable", out_data, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    armed     = 1'b0;
    chk("valid drops", out_valid, 0);
    chk("idle after handshake", busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_sat", out_sat, 0);
    chk("reset busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    beats[0] = 16'h0100; beats[1] = 16'h0280; beats[2] = 16'h8100;
    txn(3, 0, 0, 0, 0);
    chk("basic sum data", got_data, 16'h0280);
    chk("basic sum sat", got_sat, 0);

    beats[0] = 16'h7FFF; beats[1] = 16'h7FFF;
    txn(2, 0, 1, 0, 0);
    chk("pos sat data", got_data, 16'h7FFF);
    chk("pos sat flag", got_sat, 1);
    beats[0] = 16'hFFFF; beats[1] = 16'hFFFF;
    txn(2, 0, 1, 0, 0);
    chk("neg sat data", got_data, 16'hFFFF);
    chk("neg sat flag", got_sat, 1);

    txn(0, 0, 0, 0, 0);
    chk("len0 data", got_data, 16'h0000);
    chk("len0 sat", got_sat, 0);
    beats[0] = 16'h8000; beats[1] = 16'h0000;
    txn(2, 0, 0, 0, 0);
    chk("neg zero in", got_data, 16'h0000);
    beats[0] = 16'h8100; beats[1] = 16'h0100;
    txn(2, 0, 0, 0, 0);
    chk("cancel to zero", got_data, 16'h0000);

    beats[0] = 16'h0040; beats[1] = 16'h8010;
    beats[2] = 16'h0123; beats[3] = 16'h8200;
    txn(4, 3, 5, 1, 0);
    chk("handshake data", got_data, 16'h80AD);

    armed = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'd3;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid rst in_ready", in_ready, 0);
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst out_data", out_data, 0);
    chk("mid rst out_sat", out_sat, 0);
    chk("mid rst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    beats[0] = 16'h0100;
    txn(1, 0, 0, 0, 0);
    chk("post rst data", got_data, 16'h0100);

    for (int i = 0; i < 255; i++) beats[i] = 16'h7FFF;
    txn(255, 0, 2, 0, 1);
    chk("max len data", got_data, 16'h7FFF);
    chk("max len sat", got_sat, 1);

    for (int t = 0; t < 30; t++) begin
      int n;
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) begin
        beats[i] = $urandom;
        if ($urandom_range(3, 0) != 0) beats[i][14:12] = 3'b000;
      end
      txn(n, $urandom_range(3, 0), $urandom_range(4, 0),
          1'($urandom_range(1, 0)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fix_accum.md
Name: fix_accum

Overview:
- Sequential accumulator that sits directly downstream of the fixed-point multiplier.
- Consumes a stream of sign-magnitude Q-format products (MSB = sign, lower N-1 bits = magnitude, Q fraction bits) and sums a programmed number of them.
- Returns the saturated sum in the same sign-magnitude format.
- Forms the back half of the dot-product / FIR MAC path.

Parameters:
- Q, 8, number of fractional bits (informational; the sum is format-preserving, no shift).
- N, 16, data word width including sign bit.
- LEN_W, 8, width of the beat-count field; max transaction = 2^LEN_W - 1 beats.
- GUARD, 8, accumulator guard bits; accumulator width is N+GUARD, two's complement. Elaboration-time check: GUARD >= LEN_W.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, single-cycle request to begin a transaction; sampled only in IDLE.
- len, input, LEN_W, number of beats to accumulate; sampled with start.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, block accepts in_data.
- in_data, input, N, sign-magnitude product.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- out_data, output, N, sign-magnitude saturated sum.
- out_sat, output, 1, result was clipped; qualified by out_valid.
- busy, output, 1, high in ACCUM or DONE.

Behaviour:
- Reset: asynchronous. State = IDLE. Accumulator and count cleared. in_ready = 0, out_valid = 0, out_data = 0, out_sat = 0, busy = 0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start = 1 and len != 0: latch len, clear acc and cnt, go to ACCUM.
  - start = 1 and len == 0: clear acc, go to DONE. The result is 0x0000 with out_sat = 0.
  - start = 0: remain in IDLE.
- ACCUM:
  - in_ready = 1.
  - A beat is accepted when in_valid and in_ready are both high.
  - On each accepted beat: acc += sm2tc(in_data); cnt += 1.
  - On the beat where cnt == len-1: go to DONE.
  - in_valid gaps (in_valid = 0) stall with no change.
- DONE:
  - out_valid = 1.
  - out_data and out_sat are registered on entry to DONE and held stable while out_ready = 0.
  - out_valid and out_ready both high: go to IDLE. out_valid drops the next cycle.
- start outside IDLE: ignored, with no effect on the current transaction.
- sm2tc conversion: result = sign ? -mag : +mag, sign-extended to N+GUARD bits. Negative zero (0x8000 for N=16) converts to 0.
- Accumulator overflow cannot occur: the GUARD >= LEN_W check guarantees (2^LEN_W - 1)·(2^(N-1) - 1) fits in N+GUARD signed bits.
- Output conversion and saturation, with MAXM = 2^(N-1) - 1:
  - acc > MAXM: out_data = {0, all-ones magnitude}, out_sat = 1.
  - acc < -MAXM: out_data = {1, all-ones magnitude}, out_sat = 1.
  - Otherwise: sign = acc < 0, magnitude = |acc|, out_sat = 0.
  - A zero result is always emitted as 0x0000, never as negative zero.
- Latency: out_valid rises on the first clock after the last accepted beat. For len = 0, it rises on the clock after start.
- Throughput: one beat per cycle in ACCUM. There is a 1-cycle IDLE gap between transactions.
- rst asserted mid-transaction: immediate return to reset values. The partial sum is discarded and no out_valid is produced.

Decomposition:
- Shared package fix_pkg holds:
  - defaults for Q and N;
  - a function sm_to_tc(width-parameterised);
  - a function tc_to_sm_sat returning {sat, sm};
  - the state encoding localparams (IDLE / ACCUM / DONE).
- One natural sub-module: fix_sm2tc, a combinational sign-magnitude to two's-complement converter with N+GUARD output, instantiated on in_data.
- Saturation and back-conversion stay inline in the DONE-entry register logic.

Test Plan:
1. Basic sum: start with len = 3, beats 0x0100 (+1.0), 0x0280 (+2.5), 0x8100 (-1.0) → out_data = 0x0280, out_sat = 0. out_valid rises 1 cycle after the third beat.
2. Saturation: len = 2 with beats 0x7FFF, 0x7FFF → out_data 0x7FFF, out_sat = 1. Repeat with 0xFFFF, 0xFFFF → out_data 0xFFFF, out_sat = 1.
3. Zero handling:
   - len = 0 → out_valid on the cycle after start, out_data 0x0000.
   - len = 2 with 0x8000, 0x0000 → 0x0000.
   - len = 2 with 0x8100, 0x0100 → 0x0000, never 0x8000.
4. Handshake: len = 4 with in_valid gaps of 1–3 cycles between beats, and out_ready held low for 5 cycles in DONE.
   - Required: only beats with in_valid and in_ready high are summed.
   - Required: out_data is stable while stalled.
   - Required: a start pulse during ACCUM and during DONE is ignored.
   - Required: IDLE follows the out handshake.
5. Reset mid-operation: rst asserted after 1 of 3 beats → all outputs 0 immediately and no out_valid. A following transaction with len = 1 and beat 0x0100 → 0x0100.
6. Max length: len = 255 with every beat 0x7FFF → out_data 0x7FFF, out_sat = 1, with no accumulator wrap. Confirm the internal acc equals 255 × 32767 = 8,355,585.
